// File: rtl/counter3.sv
// counter3: up/down counter with a start/stop FSM (IDLE/RUN/DONE), auto-reload or oneshot mode,
// and match/wrap pulses. Define COUNTER3_PRESCALER_EN to enable the tick prescaler.
module counter3 #(
    parameter int WIDTH     = 16,
    parameter int PRE_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_desc,
    input  logic                 i_oneshot,
    input  logic [WIDTH-1:0]     i_setup,
    input  logic [PRE_WIDTH-1:0] i_prescale,
    output logic [WIDTH-1:0]     o_value,
    output logic                 o_match,
    output logic                 o_wrap,
    output logic                 o_busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic             desc_q, oneshot_q;
    logic [WIDTH-1:0] setup_q;
    logic             tick, at_fin;
    logic [WIDTH-1:0] start_val, fin_val, step_val, load_val;

    assign start_val = desc_q ? setup_q : '0;
    assign fin_val   = desc_q ? '0 : setup_q;
    assign at_fin    = (o_value == fin_val);
    assign step_val  = desc_q ? o_value - WIDTH'(1) : o_value + WIDTH'(1);
    // start value computed from the live inputs, used on the i_start cycle
    assign load_val  = i_desc ? i_setup : '0;

`ifdef COUNTER3_PRESCALER_EN
    logic [PRE_WIDTH-1:0] pre_q, pre_cnt;

    assign tick = (state == RUN) && (pre_cnt == pre_q);

    // counter returns to 0 on every tick, which also covers the reload restart
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_q   <= '0;
            pre_cnt <= '0;
        end else if (i_stop) begin
            pre_cnt <= pre_cnt;
        end else if (i_start) begin
            pre_q   <= i_prescale;
            pre_cnt <= '0;
        end else if (state == RUN) begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_WIDTH'(1);
        end
    end
`else
    logic unused_prescale;

    assign tick            = (state == RUN);
    assign unused_prescale = ^i_prescale;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (i_stop) begin
            state_nxt = IDLE;
        end else if (i_start) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:     if (tick && at_fin && oneshot_q) state_nxt = DONE;
                IDLE:    state_nxt = IDLE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy = (state == RUN);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            desc_q    <= 1'b0;
            oneshot_q <= 1'b0;
            setup_q   <= '0;
            o_value   <= '0;
            o_match   <= 1'b0;
            o_wrap    <= 1'b0;
        end else if (i_stop) begin
            o_match <= 1'b0;
            o_wrap  <= 1'b0;
        end else if (i_start) begin
            desc_q    <= i_desc;
            oneshot_q <= i_oneshot;
            setup_q   <= i_setup;
            o_value   <= load_val;
            // setup of 0 means the pass starts already on its finish value
            o_match   <= (i_setup == '0);
            o_wrap    <= 1'b0;
        end else if (tick) begin
            if (at_fin) begin
                o_wrap  <= 1'b1;
                o_value <= oneshot_q ? o_value : start_val;
                o_match <= !oneshot_q && (setup_q == '0);
            end else begin
                o_wrap  <= 1'b0;
                o_value <= step_val;
                o_match <= (step_val == fin_val);
            end
        end else begin
            o_match <= 1'b0;
            o_wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter3.sv
// Self-checking bench for counter3: expected {busy,wrap,match,value} words are queued as each
// cycle is driven and popped when the DUT outputs for that cycle are sampled.
module tb_counter3;
    localparam int W  = 16;
    localparam int PW = 8;
`ifdef COUNTER3_PRESCALER_EN
    localparam bit PRE_ON = 1'b1;
`else
    localparam bit PRE_ON = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0, i_stop = 1'b0, i_desc = 1'b0, i_oneshot = 1'b0;
    logic [W-1:0]  i_setup = '0;
    logic [PW-1:0] i_prescale = '0;
    logic [W-1:0]  o_value;
    logic          o_match, o_wrap, o_busy;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [31:0]   exp_q[$];

    counter3 #(.WIDTH(W), .PRE_WIDTH(PW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_desc(i_desc), .i_oneshot(i_oneshot), .i_setup(i_setup), .i_prescale(i_prescale),
        .o_value(o_value), .o_match(o_match), .o_wrap(o_wrap), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got b%0b w%0b m%0b v%0d, expected b%0b w%0b m%0b v%0d", tag,
                     got[18], got[17], got[16], got[15:0], exp[18], exp[17], exp[16], exp[15:0]);
        end
    endtask

    function automatic logic [31:0] pack(input int v, input bit m, input bit w, input bit b);
        logic [31:0] vv;
        vv = v;
        return {13'b0, b, w, m, vv[15:0]};
    endfunction

    function automatic logic [31:0] observed();
        return {13'b0, o_busy, o_wrap, o_match, o_value};
    endfunction

    task automatic cyc(input string tag, input int v, input bit m, input bit w, input bit b);
        exp_q.push_back(pack(v, m, w, b));
        @(posedge i_clk);
        #1;
        if (exp_q.size() == 0) check({tag, "_empty"}, observed(), 32'hffff_ffff);
        else                   check(tag, observed(), exp_q.pop_front());
    endtask

    task automatic set_cfg(input bit desc, input bit oneshot, input int setup, input int pre);
        i_desc     = desc;
        i_oneshot  = oneshot;
        i_setup    = W'(setup);
        i_prescale = PW'(pre);
    endtask

    initial begin
        int d, v;
        bit m, w;

        // reset state
        repeat (2) @(posedge i_clk);
        #1;
        exp_q.push_back(32'h0);
        check("reset", observed(), exp_q.pop_front());
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cyc("idle_after_reset", 0, 0, 0, 0);

        // up, auto-reload, setup=3
        set_cfg(0, 0, 3, 0);
        i_start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc("up_auto", k % 4, (k % 4) == 3, (k > 0) && (k % 4) == 0, 1);
            i_start = 1'b0;
        end
        i_stop = 1'b1;
        cyc("stop_hold", 1, 0, 0, 0);
        i_stop = 1'b0;

        // down, oneshot, setup=5
        set_cfg(1, 1, 5, 0);
        i_start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc("down_oneshot", 5 - k, k == 5, 0, 1);
            i_start = 1'b0;
        end
        cyc("down_wrap_done", 0, 0, 1, 0);
        set_cfg(0, 0, 7, 1);
        for (int k = 0; k < 3; k++) cyc("done_hold", 0, 0, 0, 0);

        // setup=0 auto-reload: wrap every tick
        set_cfg(0, 0, 0, 0);
        i_start = 1'b1;
        cyc("zero_first", 0, 1, 0, 1);
        i_start = 1'b0;
        for (int k = 1; k < 6; k++) cyc("zero_auto", 0, 1, 1, 1);

        // stop with simultaneous start at value 4
        set_cfg(0, 0, 10, 0);
        i_start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc("up_to_4", k, 0, 0, 1);
            i_start = 1'b0;
        end
        set_cfg(0, 0, 3, 0);
        i_stop  = 1'b1;
        i_start = 1'b1;
        cyc("stop_prio", 4, 0, 0, 0);
        i_stop  = 1'b0;
        i_start = 1'b0;
        set_cfg(1, 1, 9, 0);
        cyc("idle_hold", 4, 0, 0, 0);
        cyc("idle_hold", 4, 0, 0, 0);
        set_cfg(0, 0, 10, 0);
        i_start = 1'b1;
        cyc("restart", 0, 0, 0, 1);
        i_start = 1'b0;
        cyc("restart_step", 1, 0, 0, 1);

        // prescale=2, setup=2, up: 3 cycles per value when enabled, 1 otherwise
        d = PRE_ON ? 3 : 1;
        set_cfg(0, 0, 2, 2);
        i_start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            v = (k / d) % 3;
            m = ((k % d) == 0) && (v == 2);
            w = (k > 0) && ((k % d) == 0) && (v == 0);
            cyc("prescale", v, m, w, 1);
            i_start = 1'b0;
        end

        // asynchronous reset mid-count, no clock edge
        set_cfg(0, 0, 10, 0);
        i_start = 1'b1;
        cyc("pre_rst", 0, 0, 0, 1);
        i_start = 1'b0;
        cyc("pre_rst", 1, 0, 0, 1);
        cyc("pre_rst", 2, 0, 0, 1);
        @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        exp_q.push_back(32'h0);
        check("async_rst", observed(), exp_q.pop_front());
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) cyc("idle_after_async", 0, 0, 0, 0);
        i_start = 1'b1;
        cyc("start_after_async", 0, 0, 0, 1);
        i_start = 1'b0;
        cyc("start_after_async", 1, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
